// File: rtl/sc_down_speed_counter.sv
// rtl/sc_down_speed_counter.sv - prescaled down counter with load, start, pause and done pulse
module sc_down_speed_counter #(
    parameter int          DATAWIDTH = 8,
    parameter int unsigned PRESCALE  = 50000000
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_InHigh,
    input  logic                 CLEAR_InLow,
    input  logic                 LOAD_InLow,
    input  logic                 START_InLow,
    input  logic                 PAUSE_InLow,
    input  logic [DATAWIDTH-1:0] data_InBUS,
    output logic [DATAWIDTH-1:0] data_OutBUS,
    output logic                 running_Out,
    output logic                 done_Out,
    output logic                 zero_Out
);

    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [DATAWIDTH-1:0] r_count;
    logic [PSW-1:0]       r_ps;
    logic                 r_done;
    logic                 r_running;

    state_t               w_state_next;
    logic [DATAWIDTH-1:0] w_count_next;
    logic [PSW-1:0]       w_ps_next;
    logic                 w_done_next;

    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_ps      <= '0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_ps      <= w_ps_next;
            r_done    <= w_done_next;
            r_running <= (w_state_next == ST_RUN);
        end
    end

    // Clear beats load beats the state machine; inside RUN, pause beats stepping.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_ps_next    = r_ps;
        w_done_next  = 1'b0;

        if (!CLEAR_InLow) begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
            w_ps_next    = '0;
        end else if (!LOAD_InLow) begin
            w_state_next = ST_IDLE;
            w_count_next = data_InBUS;
            w_ps_next    = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!START_InLow && (r_count != '0)) begin
                        w_state_next = ST_RUN;
                        w_ps_next    = '0;
                    end
                end
                ST_RUN: begin
                    if (!PAUSE_InLow) begin
                        w_state_next = ST_PAUSE;
                    end else if (r_ps == PS_LAST) begin
                        w_ps_next = '0;
                        if (r_count != '0) begin
                            w_count_next = r_count - DATAWIDTH'(1);
                            if (r_count == DATAWIDTH'(1)) begin
                                w_state_next = ST_DONE;
                                w_done_next  = 1'b1;
                            end
                        end
                    end else begin
                        w_ps_next = r_ps + PSW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (!START_InLow && PAUSE_InLow) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_state_next = ST_DONE;
                end
            endcase
        end
    end

    assign data_OutBUS = r_count;
    assign running_Out = r_running;
    assign done_Out    = r_done;
    assign zero_Out    = (r_count == '0);

endmodule

// File: tb/tb_sc_down_speed_counter.sv
// tb/tb_sc_down_speed_counter.sv - directed self-checking bench for sc_down_speed_counter
module tb_sc_down_speed_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_n;
    logic       load_n;
    logic       start_n;
    logic       pause_n;
    logic [7:0] din;
    logic [7:0] dout;
    logic       running;
    logic       done;
    logic       zero;
    logic [7:0] dout1;
    logic       running1;
    logic       done1;
    logic       zero1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_down_speed_counter #(.DATAWIDTH(8), .PRESCALE(4)) dut (
        .CLOCK_50     (clk),
        .RESET_InHigh (rst),
        .CLEAR_InLow  (clr_n),
        .LOAD_InLow   (load_n),
        .START_InLow  (start_n),
        .PAUSE_InLow  (pause_n),
        .data_InBUS   (din),
        .data_OutBUS  (dout),
        .running_Out  (running),
        .done_Out     (done),
        .zero_Out     (zero)
    );

    sc_down_speed_counter #(.DATAWIDTH(8), .PRESCALE(1)) dut_p1 (
        .CLOCK_50     (clk),
        .RESET_InHigh (rst),
        .CLEAR_InLow  (clr_n),
        .LOAD_InLow   (load_n),
        .START_InLow  (start_n),
        .PAUSE_InLow  (pause_n),
        .data_InBUS   (din),
        .data_OutBUS  (dout1),
        .running_Out  (running1),
        .done_Out     (done1),
        .zero_Out     (zero1)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] c, input logic r,
                           input logic d, input logic z);
        chk({tag, ".count"}, {24'd0, dout}, {24'd0, c});
        chk({tag, ".running"}, {31'd0, running}, {31'd0, r});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
    endtask

    initial begin
        rst = 1'b1; clr_n = 1'b1; load_n = 1'b1; start_n = 1'b1; pause_n = 1'b1; din = 8'h00;
        step(1);
        chk_out("reset", 8'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        step(1);

        // Load 3 and run to done
        din = 8'd3; load_n = 1'b0; step(1); load_n = 1'b1;
        chk_out("load3", 8'd3, 1'b0, 1'b0, 1'b0);
        start_n = 1'b0; step(1); start_n = 1'b1;
        chk_out("run3.start", 8'd3, 1'b1, 1'b0, 1'b0);
        step(3);
        chk_out("run3.c3", 8'd3, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_out("run3.c2", 8'd2, 1'b1, 1'b0, 1'b0);
        step(4);
        chk_out("run3.c1", 8'd1, 1'b1, 1'b0, 1'b0);
        step(4);
        chk_out("run3.done", 8'd0, 1'b0, 1'b1, 1'b1);
        step(1);
        chk_out("run3.after", 8'd0, 1'b0, 1'b0, 1'b1);

        // Load 5, pause with prescaler at 2, resume
        din = 8'd5; load_n = 1'b0; step(1); load_n = 1'b1;
        start_n = 1'b0; step(1); start_n = 1'b1;
        step(6);
        chk_out("pause.pre", 8'd4, 1'b1, 1'b0, 1'b0);
        pause_n = 1'b0; step(1);
        chk_out("pause.enter", 8'd4, 1'b0, 1'b0, 1'b0);
        start_n = 1'b0; step(4); start_n = 1'b1;
        chk_out("pause.bothlow", 8'd4, 1'b0, 1'b0, 1'b0);
        step(5);
        chk_out("pause.hold", 8'd4, 1'b0, 1'b0, 1'b0);
        pause_n = 1'b1; start_n = 1'b0; step(1); start_n = 1'b1;
        chk_out("pause.resume", 8'd4, 1'b1, 1'b0, 1'b0);
        step(2);
        chk_out("pause.c3", 8'd3, 1'b1, 1'b0, 1'b0);
        step(11);
        chk_out("pause.c1", 8'd1, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_out("pause.done", 8'd0, 1'b0, 1'b1, 1'b1);

        // Load 0 then start is ignored
        din = 8'd0; load_n = 1'b0; step(1); load_n = 1'b1;
        start_n = 1'b0; step(2); start_n = 1'b1;
        chk_out("zero.start", 8'd0, 1'b0, 1'b0, 1'b1);

        // Clear beats load mid-run at count 7
        din = 8'd8; load_n = 1'b0; step(1); load_n = 1'b1;
        start_n = 1'b0; step(1); start_n = 1'b1;
        step(4);
        chk_out("mid.c7", 8'd7, 1'b1, 1'b0, 1'b0);
        din = 8'h20; load_n = 1'b0; clr_n = 1'b0; step(1);
        chk_out("mid.clear", 8'd0, 1'b0, 1'b0, 1'b1);
        clr_n = 1'b1; step(1); load_n = 1'b1;
        chk_out("mid.load", 8'h20, 1'b0, 1'b0, 1'b0);

        // Reset mid-run, then start with count 0 ignored
        start_n = 1'b0; step(1); start_n = 1'b1;
        step(5);
        chk_out("rst.running", 8'h1f, 1'b1, 1'b0, 1'b0);
        rst = 1'b1; start_n = 1'b0; step(1); rst = 1'b0;
        chk_out("rst.hit", 8'd0, 1'b0, 1'b0, 1'b1);
        step(1); start_n = 1'b1;
        chk_out("rst.start", 8'd0, 1'b0, 1'b0, 1'b1);

        // Done state ignores start; reload restarts
        din = 8'd1; load_n = 1'b0; step(1); load_n = 1'b1;
        start_n = 1'b0; step(1); start_n = 1'b1;
        step(4);
        chk_out("done1.pulse", 8'd0, 1'b0, 1'b1, 1'b1);
        start_n = 1'b0; step(2); start_n = 1'b1;
        chk_out("done1.start", 8'd0, 1'b0, 1'b0, 1'b1);
        din = 8'd2; load_n = 1'b0; step(1); load_n = 1'b1;
        chk_out("done2.load", 8'd2, 1'b0, 1'b0, 1'b0);
        chk("p1.load", {24'd0, dout1}, 32'd2);
        start_n = 1'b0; step(1); start_n = 1'b1;
        chk("p1.start", {24'd0, dout1}, 32'd2);
        chk("p1.run", {31'd0, running1}, 32'd1);
        step(1);
        chk("p1.c1", {24'd0, dout1}, 32'd1);
        step(1);
        chk("p1.c0", {24'd0, dout1}, 32'd0);
        chk("p1.done", {31'd0, done1}, 32'd1);
        chk("p1.zero", {31'd0, zero1}, 32'd1);
        step(5);
        chk_out("done2.c1", 8'd1, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_out("done2.pulse", 8'd0, 1'b0, 1'b1, 1'b1);
        step(1);
        chk_out("done2.after", 8'd0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_down_speed_counter.md
SC_DOWN_SPEED_COUNTER -- requirements
Module: sc_down_speed_counter

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, count width in bits.
REQ-002 SHALL have parameter PRESCALE, default 50000000, clock cycles per count step; legal range 1..2^32-1.
REQ-003 SHALL have port CLOCK_50  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET_InHigh  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CLEAR_InLow  input  1  active-low synchronous clear of count and state.
REQ-006 SHALL have port LOAD_InLow  input  1  active-low load strobe for data_InBUS.
REQ-007 SHALL have port START_InLow  input  1  active-low start/resume request.
REQ-008 SHALL have port PAUSE_InLow  input  1  active-low pause request.
REQ-009 SHALL have port data_InBUS  input  DATAWIDTH  preset value captured on load.
REQ-010 SHALL have port data_OutBUS  output  DATAWIDTH  current count, registered.
REQ-011 SHALL have port running_Out  output  1  high while state is RUN, registered.
REQ-012 SHALL have port done_Out  output  1  one-cycle pulse when count reaches zero from RUN, registered.
REQ-013 SHALL have port zero_Out  output  1  high whenever data_OutBUS equals 0.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE, DONE, plus a prescaler counter of width ceil(log2(PRESCALE)), minimum 1 bit.
REQ-015 SHALL apply per-cycle priority: reset > clear > load > pause > start > prescaler/decrement.
REQ-016 Clear (CLEAR_InLow=0): count=0, prescaler=0, state=IDLE, done_Out=0, regardless of state.
REQ-017 Load (LOAD_InLow=0): count=data_InBUS, prescaler=0, state=IDLE, in any state, including mid-RUN.
REQ-018 IDLE + START_InLow=0 + count!=0: state=RUN next cycle, prescaler=0; count==0: start ignored, stay IDLE.
REQ-019 RUN: prescaler increments each cycle; when prescaler==PRESCALE-1, prescaler=0 and count decrements by 1 in the same edge.
REQ-020 RUN, decrement from 1 to 0: state=DONE and done_Out=1 on that same edge; done_Out=0 on the following edge.
REQ-021 RUN + PAUSE_InLow=0: state=PAUSE; prescaler and count hold; no decrement that cycle even if prescaler==PRESCALE-1.
REQ-022 PAUSE + START_InLow=0 + PAUSE_InLow=1: state=RUN, prescaler resumes from held value; both low: remain PAUSE.
REQ-023 DONE: count holds 0, start ignored; exit only via load (to IDLE) or clear/reset.
REQ-024 Count SHALL never wrap below 0; decrement is suppressed when count==0.
REQ-025 PRESCALE=1: count decrements every RUN cycle.
REQ-026 START_InLow held low is level-sensitive; no edge detection required.
REQ-027 running_Out=1 exactly when state==RUN; zero_Out is combinational from the count register.

Reset
REQ-028 On RESET_InHigh=1 at a rising edge: count=0, prescaler=0, state=IDLE, running_Out=0, done_Out=0, zero_Out=1.
REQ-029 Reset SHALL override all other inputs, including asserted mid-RUN, and take effect on that edge only (no asynchronous path).

Verification (PRESCALE=4, DATAWIDTH=8)
REQ-030 Load 3, start one cycle -> running_Out=1; count 3->2->1->0 at 4-cycle intervals; done_Out high exactly 1 cycle with count=0; state DONE, running_Out=0.
REQ-031 Load 5, start, pause after 6 RUN cycles for 10 cycles, resume -> count holds 4 during pause; 0 reached 14 RUN cycles after resume (prescaler value 2 preserved).
REQ-032 Load 0, start -> stays IDLE, running_Out=0, done_Out never asserts, zero_Out=1.
REQ-033 Mid-RUN at count 7: LOAD_InLow=0 with data_InBUS=0x20 and CLEAR_InLow=0 same cycle -> count=0, IDLE (clear wins); next: load 0x20 alone -> count=0x20, IDLE.
REQ-034 Mid-RUN: RESET_InHigh=1 for one cycle -> next edge count=0, IDLE, all outputs at reset values; START afterwards with count 0 ignored.
REQ-035 DONE state: START_InLow=0 -> no change; LOAD 2 then start -> counts down again, second done_Out pulse.
